s1494_cone_sched: RTL and testbench

S1494_CONE_SCHED -- requirements
Module: s1494_cone_sched

---
 rtl/s1494_pkg.sv | 16 +
 rtl/s1494_cone_wdog.sv | 28 ++
 rtl/s1494_cone_sched.sv | 121 ++++++++++++
 tb/tb_s1494_cone_sched.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/s1494_pkg.sv
// Shared FSM encoding, cone count and cone_in field positions for the s1494 cone scheduler.
package s1494_pkg;
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EVAL = 2'd1,
    EMIT = 2'd2
  } state_t;

  localparam int NCONE     = 6;
  localparam int SW        = 6;
  localparam int NPI       = 7;
  localparam int CI_PI_LSB = 0;
  localparam int CI_ST_LSB = 7;
  localparam int CI_CLR    = 13;
  localparam int CI_W      = 14;
endpackage

// File: rtl/s1494_cone_wdog.sv
// Cone-ack wait counter: fires expire on the TIMEOUT-th cycle a request goes unanswered.
// Restarts on every capture (ack or expiry) and whenever the scheduler is not evaluating.
module s1494_cone_wdog #(
  parameter int TIMEOUT = 16
) (
  input  logic clock,
  input  logic reset,
  input  logic run,
  input  logic ack,
  output logic expire
);
  localparam int CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] cnt;

  // A late ack in the final wait cycle still wins over the timeout.
  assign expire = run && !ack && (cnt == CW'(TIMEOUT - 1));

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (!run || ack || expire) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end
endmodule

// File: rtl/s1494_cone_sched.sv
// Steps the s1494 state machine by sequencing NCONE next-state cones through a shared evaluator.
// Results collect in a shadow register and commit to st_q in one edge, so partial steps never show.
module s1494_cone_sched #(
  parameter int NCONE   = s1494_pkg::NCONE,
  parameter int TIMEOUT = 16
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        vec_valid,
  output logic        vec_ready,
  input  logic [6:0]  vec_pi,
  input  logic        vec_clr,
  output logic        cone_req,
  output logic [2:0]  cone_sel,
  output logic [13:0] cone_in,
  input  logic        cone_ack,
  input  logic        cone_bit,
  output logic        st_valid,
  input  logic        st_ready,
  output logic [5:0]  st_q,
  output logic        err
);
  import s1494_pkg::*;

  state_t          state;
  logic [2:0]      k;
  logic [NPI-1:0]  pi_l;
  logic            clr_l;
  logic [SW-1:0]   shadow;
  logic [SW-1:0]   shadow_nxt;
  logic            expire;
  logic            last;

  assign cone_sel = k;
  assign last     = (k == 3'(NCONE - 1));

  always_comb begin
    cone_in                     = '0;
    cone_in[CI_PI_LSB +: NPI]   = pi_l;
    cone_in[CI_ST_LSB +: SW]    = st_q;
    cone_in[CI_CLR]             = clr_l;
  end

  // A timed-out cone captures 0 because cone_bit is only meaningful alongside cone_ack.
  always_comb begin
    shadow_nxt    = shadow;
    shadow_nxt[k] = cone_ack & cone_bit;
  end

  s1494_cone_wdog #(
    .TIMEOUT(TIMEOUT)
  ) u_wdog (
    .clock (clock),
    .reset (reset),
    .run   (state == EVAL),
    .ack   (cone_ack),
    .expire(expire)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      k         <= '0;
      pi_l      <= '0;
      clr_l     <= 1'b0;
      shadow    <= '0;
      st_q      <= '0;
      err       <= 1'b0;
      cone_req  <= 1'b0;
      st_valid  <= 1'b0;
      vec_ready <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (vec_valid) begin
            pi_l      <= vec_pi;
            clr_l     <= vec_clr;
            k         <= '0;
            vec_ready <= 1'b0;
            if (vec_clr) begin
              state    <= EVAL;
              cone_req <= 1'b1;
            end else begin
              shadow   <= '0;
              st_q     <= '0;
              state    <= EMIT;
              st_valid <= 1'b1;
            end
          end
        end
        EVAL: begin
          if (cone_ack || expire) begin
            shadow <= shadow_nxt;
            if (expire) begin
              err <= 1'b1;
            end
            if (last) begin
              st_q     <= shadow_nxt;
              k        <= '0;
              cone_req <= 1'b0;
              st_valid <= 1'b1;
              state    <= EMIT;
            end else begin
              k <= k + 3'd1;
            end
          end
        end
        EMIT: begin
          if (st_ready) begin
            st_valid  <= 1'b0;
            vec_ready <= 1'b1;
            state     <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_s1494_cone_sched.sv
// Bench for s1494_cone_sched: directed table, multi-cycle corner sequences, then random steps vs a golden model.
module tb_s1494_cone_sched;
  logic        clock = 1'b0;
  logic        reset;
  logic        vec_valid;
  logic        vec_ready;
  logic [6:0]  vec_pi;
  logic        vec_clr;
  logic        cone_req;
  logic [2:0]  cone_sel;
  logic [13:0] cone_in;
  logic        cone_ack;
  logic        cone_bit;
  logic        st_valid;
  logic        st_ready;
  logic [5:0]  st_q;
  logic        err;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  s1494_cone_sched #(.NCONE(6), .TIMEOUT(16)) dut (
    .clock    (clock),
    .reset    (reset),
    .vec_valid(vec_valid),
    .vec_ready(vec_ready),
    .vec_pi   (vec_pi),
    .vec_clr  (vec_clr),
    .cone_req (cone_req),
    .cone_sel (cone_sel),
    .cone_in  (cone_in),
    .cone_ack (cone_ack),
    .cone_bit (cone_bit),
    .st_valid (st_valid),
    .st_ready (st_ready),
    .st_q     (st_q),
    .err      (err)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  initial begin
    #1500000;
    $display("FAIL global_timeout act=running exp=finished");
    $fatal(1, "bench did not finish");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s act=0x%0h exp=0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference next-state cones: arbitrary parity functions over all 14 cone inputs.
  function automatic logic golden(input logic [2:0] k, input logic [13:0] x);
    logic [13:0] m;
    case (k)
      3'd0:    m = 14'h2A5B;
      3'd1:    m = 14'h1C37;
      3'd2:    m = 14'h3349;
      3'd3:    m = 14'h0F96;
      3'd4:    m = 14'h25E1;
      3'd5:    m = 14'h38AC;
      default: m = 14'h0000;
    endcase
    return (^(x & m)) ^ k[0];
  endfunction

  // Offers one vector and plays the cone evaluator until st_valid; st_ready is left low.
  task automatic do_step(input logic [6:0] pi, input logic clr, input int mode,
                         input logic [5:0] tbits, input int max_dly, input int drop_k,
                         input logic [5:0] prev_st,
                         output logic [5:0] q, output int lat, output int nreq);
    int c0, budget, dly, cur;
    logic [13:0] exp_in;
    budget = 0;
    while (!vec_ready && budget < 100) begin
      @(negedge clock);
      budget++;
    end
    if (!vec_ready) chk("vec_ready_wait", 32'(vec_ready), 32'd1);
    vec_valid = 1'b1;
    vec_pi    = pi;
    vec_clr   = clr;
    c0        = cyc;
    @(negedge clock);
    vec_valid = 1'b0;
    exp_in = {clr, prev_st, pi};
    cur = -1; nreq = 0; dly = 0; budget = 0; q = '0; lat = -1;
    while (!st_valid && budget < 500) begin
      cone_ack = 1'b0;
      if (cone_req) begin
        if (int'(cone_sel) != cur) begin
          cur = int'(cone_sel);
          nreq++;
          dly = int'($urandom_range(max_dly, 0));
          chk("cone_in", 32'(cone_in), 32'(exp_in));
        end
        if (cur != drop_k) begin
          if (dly == 0) begin
            cone_ack = 1'b1;
            cone_bit = (mode != 0) ? golden(cone_sel, cone_in) : tbits[cone_sel];
          end else begin
            dly--;
          end
        end
      end
      @(negedge clock);
      budget++;
    end
    cone_ack = 1'b0;
    if (st_valid) begin
      q   = st_q;
      lat = cyc - c0;
    end else begin
      chk("st_valid_wait", 32'(st_valid), 32'd1);
    end
  endtask

  task automatic release_st(input int hold);
    repeat (hold) @(negedge clock);
    st_ready = 1'b1;
    @(negedge clock);
    st_ready = 1'b0;
  endtask

  typedef struct {
    logic [6:0] pi;
    logic       clr;
    logic [5:0] bits;
    logic [5:0] exp_q;
    int         exp_lat;
    int         exp_nreq;
  } vec_t;

  vec_t tbl[6];

  initial begin
    logic [5:0] q, ref_state, exp_q;
    logic [6:0] pi;
    logic       clr;
    int         lat, nreq, budget;

    tbl[0] = '{pi: 7'h55, clr: 1'b1, bits: 6'b101010, exp_q: 6'b101010, exp_lat: 7, exp_nreq: 6};
    tbl[1] = '{pi: 7'h7F, clr: 1'b1, bits: 6'h3F,     exp_q: 6'h3F,     exp_lat: 7, exp_nreq: 6};
    tbl[2] = '{pi: 7'h55, clr: 1'b0, bits: 6'h15,     exp_q: 6'h00,     exp_lat: 1, exp_nreq: 0};
    tbl[3] = '{pi: 7'h0A, clr: 1'b1, bits: 6'h15,     exp_q: 6'h15,     exp_lat: 7, exp_nreq: 6};
    tbl[4] = '{pi: 7'h3C, clr: 1'b1, bits: 6'h00,     exp_q: 6'h00,     exp_lat: 7, exp_nreq: 6};
    tbl[5] = '{pi: 7'h01, clr: 1'b1, bits: 6'h2C,     exp_q: 6'h2C,     exp_lat: 7, exp_nreq: 6};

    reset = 1'b1; vec_valid = 1'b0; vec_pi = '0; vec_clr = 1'b1;
    cone_ack = 1'b0; cone_bit = 1'b0; st_ready = 1'b0;
    repeat (3) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    chk("rst_vec_ready", 32'(vec_ready), 32'd1);
    chk("rst_cone_req", 32'(cone_req), 32'd0);
    chk("rst_st_valid", 32'(st_valid), 32'd0);
    chk("rst_st_q", 32'(st_q), 32'd0);
    chk("rst_err", 32'(err), 32'd0);

    ref_state = '0;
    foreach (tbl[i]) begin
      do_step(tbl[i].pi, tbl[i].clr, 0, tbl[i].bits, 0, -1, ref_state, q, lat, nreq);
      chk("tbl_st_q", 32'(q), 32'(tbl[i].exp_q));
      chk("tbl_latency", 32'(lat), 32'(tbl[i].exp_lat));
      chk("tbl_nreq", 32'(nreq), 32'(tbl[i].exp_nreq));
      chk("tbl_err", 32'(err), 32'd0);
      ref_state = tbl[i].exp_q;
      release_st(0);
    end

    // Consumer stall in EMIT while another vector is offered.
    do_step(7'h21, 1'b1, 0, 6'h21, 0, -1, ref_state, q, lat, nreq);
    ref_state = 6'h21;
    vec_valid = 1'b1; vec_pi = 7'h12; vec_clr = 1'b1;
    for (int h = 0; h < 5; h++) begin
      @(negedge clock);
      chk("hold_st_valid", 32'(st_valid), 32'd1);
      chk("hold_st_q", 32'(st_q), 32'h21);
      chk("hold_vec_ready", 32'(vec_ready), 32'd0);
      chk("hold_cone_req", 32'(cone_req), 32'd0);
    end
    vec_valid = 1'b0;
    st_ready  = 1'b1;
    @(negedge clock);
    st_ready = 1'b0;
    chk("hold_rel_vec_ready", 32'(vec_ready), 32'd1);
    chk("hold_rel_st_valid", 32'(st_valid), 32'd0);

    // Cone 2 never answers: zero captured on the 16th wait cycle.
    do_step(7'h33, 1'b1, 0, 6'h3F, 0, 2, ref_state, q, lat, nreq);
    chk("tmo_st_q", 32'(q), 32'b111011);
    chk("tmo_latency", 32'(lat), 32'd22);
    chk("tmo_nreq", 32'(nreq), 32'd6);
    chk("tmo_err", 32'(err), 32'd1);
    release_st(0);
    chk("tmo_err_sticky", 32'(err), 32'd1);

    // Reset mid-evaluation at cone 3, then a stray ack.
    vec_valid = 1'b1; vec_pi = 7'h44; vec_clr = 1'b1;
    @(negedge clock);
    vec_valid = 1'b0;
    budget = 0;
    while (!(cone_req && cone_sel == 3'd3) && budget < 50) begin
      cone_ack = cone_req;
      cone_bit = 1'b1;
      @(negedge clock);
      budget++;
    end
    chk("rst_eval_reached_k3", 32'(cone_sel), 32'd3);
    cone_ack = 1'b0;
    #2 reset = 1'b1;
    #1;
    chk("async_rst_cone_req", 32'(cone_req), 32'd0);
    chk("async_rst_st_q", 32'(st_q), 32'd0);
    @(negedge clock);
    reset = 1'b0;
    cone_ack = 1'b1; cone_bit = 1'b1;
    @(negedge clock);
    cone_ack = 1'b0;
    @(negedge clock);
    chk("post_rst_st_q", 32'(st_q), 32'd0);
    chk("post_rst_vec_ready", 32'(vec_ready), 32'd1);
    chk("post_rst_cone_req", 32'(cone_req), 32'd0);
    chk("post_rst_st_valid", 32'(st_valid), 32'd0);
    chk("post_rst_err", 32'(err), 32'd0);

    // Random steps against the golden cone model with random evaluator latency.
    ref_state = '0;
    for (int n = 0; n < 1000; n++) begin
      pi  = 7'($urandom);
      clr = ($urandom_range(7, 0) != 0);
      exp_q = '0;
      if (clr) begin
        for (int kk = 0; kk < 6; kk++) exp_q[kk] = golden(3'(kk), {1'b1, ref_state, pi});
      end
      do_step(pi, clr, 1, 6'h00, 10, -1, ref_state, q, lat, nreq);
      chk("rand_st_q", 32'(q), 32'(exp_q));
      ref_state = exp_q;
      release_st(int'($urandom_range(2, 0)));
    end
    chk("rand_err", 32'(err), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
